// File: rtl/cla16_sig_checker.sv
// MISR response checker for the 16-bit CLA: compacts {cout,sum}
// over N_PATTERNS words, then compares against golden_sig.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start            run request (IDLE/DONE only)
//   in_valid         sum_in/cout_in carry a word this cycle
//   sum_in, cout_in  adder result under test
//   golden_sig       expected signature
//   busy, done       RUN / DONE state flags
//   pass             compare result (valid while done)
//   signature, count MISR contents, accepted word count
module cla16_sig_checker #(
  parameter int unsigned N_PATTERNS = 256,
  parameter logic [16:0] SEED       = 17'h00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] sum_in,
  input  logic        cout_in,
  input  logic [16:0] golden_sig,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [16:0] signature,
  output logic [15:0] count
);

  localparam logic [15:0] LAST = 16'(N_PATTERNS - 1);
  localparam logic [15:0] FULL = 16'(N_PATTERNS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [16:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pass_q, pass_d;

  logic [16:0] d_word;
  logic [16:0] sig_nxt;

  assign d_word = {cout_in, sum_in};

  // x^17+x^3+1: rotate left, feedback bit also folds into bit 3
  assign sig_nxt = {sig_q[15:0], sig_q[16]}
                 ^ {13'b0, sig_q[16], 3'b0}
                 ^ d_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        // start wins over a coincident in_valid word
        if (start) begin
          state_d = RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (in_valid) begin
          sig_d = sig_nxt;
          if (cnt_q == LAST) begin
            cnt_d   = FULL;
            pass_d  = (sig_nxt == golden_sig);
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_cla16_sig_checker.sv
// Bench for cla16_sig_checker: three instances (N=4,1,2)
// share stimulus and are checked against a behavioural model.
module tb_cla16_sig_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [15:0] sum_in;
  logic        cout_in;
  logic [16:0] golden_sig;

  logic [2:0]  busy, done, pass;
  logic [16:0] sig [3];
  logic [15:0] cnt [3];

  int total = 0;
  int bad   = 0;

  localparam int NP [3] = '{4, 1, 2};

  cla16_sig_checker #(.N_PATTERNS(4), .SEED(17'h0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .sum_in(sum_in), .cout_in(cout_in),
    .golden_sig(golden_sig), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .signature(sig[0]), .count(cnt[0]));

  cla16_sig_checker #(.N_PATTERNS(1), .SEED(17'h0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .sum_in(sum_in), .cout_in(cout_in),
    .golden_sig(golden_sig), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .signature(sig[1]), .count(cnt[1]));

  cla16_sig_checker #(.N_PATTERNS(2), .SEED(17'h0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .sum_in(sum_in), .cout_in(cout_in),
    .golden_sig(golden_sig), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .signature(sig[2]), .count(cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // signature arithmetic: multiply by x modulo x^17+x^3+1, add data
  function automatic logic [16:0] misr(input logic [16:0] s,
                                       input logic [16:0] d);
    logic [17:0] t;
    t = {s, 1'b0};
    if (t[17]) t = t ^ 18'h20009;
    return t[16:0] ^ d;
  endfunction

  // model: run flag, done flag, signature, count, pass
  logic        m_run  [3];
  logic        m_done [3];
  logic [16:0] m_sig  [3];
  int          m_cnt  [3];
  logic        m_pass [3];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_run[k]  <= 1'b0;
        m_done[k] <= 1'b0;
        m_sig[k]  <= 17'h0;
        m_cnt[k]  <= 0;
        m_pass[k] <= 1'b0;
      end else if (!m_run[k] && start) begin
        m_run[k]  <= 1'b1;
        m_done[k] <= 1'b0;
        m_sig[k]  <= 17'h0;
        m_cnt[k]  <= 0;
        m_pass[k] <= 1'b0;
      end else if (m_run[k] && in_valid) begin
        m_sig[k] <= misr(m_sig[k], {cout_in, sum_in});
        m_cnt[k] <= m_cnt[k] + 1;
        if (m_cnt[k] + 1 == NP[k]) begin
          m_run[k]  <= 1'b0;
          m_done[k] <= 1'b1;
          m_pass[k] <= (misr(m_sig[k], {cout_in, sum_in})
                        == golden_sig);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_run[k]));
      chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
      chk($sformatf("sig%0d", k), 32'(sig[k]), 32'(m_sig[k]));
      chk($sformatf("cnt%0d", k), 32'(cnt[k]), 32'(m_cnt[k]));
      if (m_done[k])
        chk($sformatf("pass%0d", k), 32'(pass[k]), 32'(m_pass[k]));
    end
  end

  task automatic cyc(input logic s, input logic v,
                     input logic [16:0] d);
    start    = s;
    in_valid = v;
    cout_in  = d[16];
    sum_in   = d[15:0];
    @(posedge clk);
    #2;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  logic [16:0] add_res;
  logic [15:0] a_op, b_op;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    sum_in     = '0;
    cout_in    = 1'b0;
    golden_sig = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_sig", 32'(sig[0]), 0);
    chk("rst_cnt", 32'(cnt[0]), 0);
    rst_n = 1'b1;

    // A: four zero words, golden 0
    cyc(1, 0, 17'h0);
    chk("a_busy", 32'(busy[0]), 1);
    repeat (3) cyc(0, 1, 17'h0);
    chk("a_early", 32'(done[0]), 0);
    cyc(0, 1, 17'h0);
    chk("a_done", 32'(done[0]), 1);
    chk("a_sig", 32'(sig[0]), 32'h0);
    chk("a_cnt", 32'(cnt[0]), 4);
    chk("a_pass", 32'(pass[0]), 1);

    // B: 32767+32768+1 -> sum 0, cout 1
    pulse_reset();
    golden_sig = 17'h10000;
    a_op = 16'd32767;
    b_op = 16'd32768;
    add_res = {1'b0, a_op} + {1'b0, b_op} + 17'd1;
    cyc(1, 0, 17'h0);
    cyc(0, 1, add_res);
    chk("b_done", 32'(done[1]), 1);
    chk("b_sig", 32'(sig[1]), 32'h10000);
    chk("b_pass", 32'(pass[1]), 1);

    // C: two words, golden 9
    pulse_reset();
    golden_sig = 17'h00009;
    cyc(1, 0, 17'h0);
    cyc(0, 1, 17'h10000);
    cyc(0, 1, 17'h00000);
    chk("c_model", 32'(m_sig[2]), 32'h9);
    chk("c_sig", 32'(sig[2]), 32'h9);
    chk("c_pass", 32'(pass[2]), 1);

    // D: restart from DONE with wrong golden
    golden_sig = 17'h00008;
    cyc(1, 0, 17'h0);
    chk("d_restart", 32'(done[2]), 0);
    cyc(0, 1, 17'h10000);
    cyc(0, 1, 17'h00000);
    chk("d_done", 32'(done[2]), 1);
    chk("d_pass", 32'(pass[2]), 0);

    // E: gaps and starts during RUN
    pulse_reset();
    golden_sig = 17'h00009;
    cyc(1, 0, 17'h0);
    cyc(0, 1, 17'h10000);
    cyc(0, 0, 17'h1ffff);
    chk("e_gap1", 32'(busy[2]), 1);
    cyc(1, 0, 17'h0);
    chk("e_gap2", 32'(busy[2]), 1);
    chk("e_hold", 32'(sig[2]), 32'h10000);
    cyc(0, 1, 17'h00000);
    chk("e_sig", 32'(sig[2]), 32'h9);
    chk("e_cnt", 32'(cnt[2]), 2);
    chk("e_pass", 32'(pass[2]), 1);

    // F: reset mid-run, then a clean run
    pulse_reset();
    golden_sig = 17'h0;
    cyc(1, 0, 17'h0);
    cyc(0, 1, 17'h01234);
    #1 rst_n = 1'b0;
    #1;
    chk("f_busy", 32'(busy[0]), 0);
    chk("f_done", 32'(done[0]), 0);
    chk("f_sig", 32'(sig[0]), 0);
    chk("f_cnt", 32'(cnt[0]), 0);
    #1 rst_n = 1'b1;
    cyc(1, 0, 17'h0);
    repeat (4) cyc(0, 1, 17'h0);
    chk("f_redone", 32'(done[0]), 1);
    chk("f_repass", 32'(pass[0]), 1);

    // random traffic; start+valid collisions included
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0)
        golden_sig = 17'($urandom);
      cyc(($urandom_range(0, 7) == 0),
          ($urandom_range(0, 1) == 1),
          17'($urandom));
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    repeat (2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla16_sig_checker.md
Name: cla16_sig_checker

Overview:
- Response-side partner to the 16-bit CLA stimulus bench. It sits at the output of bit16_cla.
- Compacts the adder's {cout, sum} result stream into a 17-bit MISR signature over a fixed number of accepted patterns.
- Compares the final signature with a golden value and reports pass/fail through a start/done handshake.
- Used in the CLA+LFSR lab for self-checking in simulation and on the board.

Parameters:
- N_PATTERNS, 256: number of accepted result words per run (1..65535).
- SEED, 17'h00000: MISR value loaded on start.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle run request; honoured only in IDLE or DONE.
- in_valid  input  1  sum_in/cout_in hold a result to compact this cycle.
- sum_in  input  16  adder sum under test.
- cout_in  input  1  adder carry-out under test.
- golden_sig  input  17  expected signature; must be stable from start until done.
- busy  output  1  high in RUN.
- done  output  1  high in DONE; held until next start.
- pass  output  1  registered compare result; valid only while done=1.
- signature  output  17  current MISR contents.
- count  output  16  number of words accepted in this run.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, pass=0, signature=SEED, count=0.
  - Applies immediately, including mid-run. Any partial signature is discarded.
- States: IDLE, RUN, DONE. Transitions are on the rising clk edge.
- IDLE → RUN when start=1.
  - Same edge: signature←SEED, count←0, pass←0.
  - busy=1 from the following cycle.
- DONE → RUN when start=1, with the same loads as above; done drops.
- RUN, in_valid=0: hold signature and count.
- RUN, in_valid=1:
  - d = {cout_in, sum_in} (d[16]=cout).
  - MISR update, polynomial x^17+x^3+1:
    - sig'[0] = sig[16]^d[0]
    - sig'[3] = sig[2]^sig[16]^d[3]
    - sig'[i] = sig[i-1]^d[i] for every other i in 1..16.
  - count←count+1.
- Terminal word, i.e. accepted while count==N_PATTERNS-1:
  - Same edge: signature←sig', count←N_PATTERNS, pass←(sig'==golden_sig), state←DONE.
  - done=1 and busy=0 from the next cycle.
  - Latency from the final valid word to done is 1 clock.
- start while in RUN: ignored, no restart.
- in_valid in IDLE or DONE: ignored, no state change.
- start and in_valid together in IDLE or DONE: the start load wins. That in_valid word is not compacted.
- count never exceeds N_PATTERNS and never wraps.
- Outputs stay stable in DONE until start or reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then N_PATTERNS=4, start, 4 valid words of 0, golden=0 → done high 1 cycle after the 4th word; signature=17'h00000, count=4, pass=1.
- N_PATTERNS=1, start, one word ain=32767, bin=32768, cin=1 (sum=16'h0000, cout=1), golden=17'h10000 → signature=17'h10000, pass=1.
- N_PATTERNS=2, words d=17'h10000 then d=17'h00000, golden=17'h00009 → signature=17'h00009, pass=1.
- Repeat the previous case with golden=17'h00008 → pass=0, done=1.
- N_PATTERNS=2, in_valid gaps (pattern 1,0,0,1) → identical signature 17'h00009; busy held through the gaps; extra start pulses during RUN have no effect.
- Assert rst_n=0 mid-run after 1 word → immediately busy=0, done=0, signature=0, count=0. A fresh start then completes normally.
